wb_port_arbiter: RTL and testbench

Arbiter and sequencer for the register-file write port. Three requesters share the single 5-bit destination-address / 32-bit data write path:

- pipeline writeback (req 0)
- multdiv completion (req 1)
- special-register write for `$r30` status / `$r31` link (req 2)

The block grants one requester per cycle and drives the 2-bit mux select (`00`/`01`/`10` → req 0/1/2). It registers the selected write, and stalls the losing requesters until they are served.

---
 rtl/wbarb_pkg.sv | 35 +++
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wbarb_starve_ctr.sv | 28 ++
 rtl/wb_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wbarb_pkg.sv
// Shared constants and payload type for the register-file write-port arbiter.
package wbarb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 2;

  localparam int unsigned REQ_WB  = 0;
  localparam int unsigned REQ_MD  = 1;
  localparam int unsigned REQ_SPR = 2;

  localparam logic [SEL_W-1:0] SEL_0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_2 = 2'b10;

  localparam logic [ADDR_W-1:0] R0_ADDR = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // One-hot grant to mux select; an empty grant maps to SEL_0, 2'b11 is never produced.
  function automatic logic [SEL_W-1:0] gnt_to_sel(input logic [NUM_REQ-1:0] gnt);
    logic [SEL_W-1:0] sel;
    case (gnt)
      3'b010:  sel = SEL_1;
      3'b100:  sel = SEL_2;
      default: sel = SEL_0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Request/grant and registered write bus between the requesters and the write-port arbiter.
interface wb_port_arbiter_if;
  import wbarb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [ADDR_W-1:0]  addr2;
  logic [DATA_W-1:0]  data0;
  logic [DATA_W-1:0]  data1;
  logic [DATA_W-1:0]  data2;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] stall;
  logic [SEL_W-1:0]   sel;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  modport slave (
    input  req, addr0, addr1, addr2, data0, data1, data2,
    output gnt, stall, sel, wr_en, wr_addr, wr_data
  );

  modport master (
    output req, addr0, addr1, addr2, data0, data1, data2,
    input  gnt, stall, sel, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/wbarb_starve_ctr.sv
// Saturating wait counter for one requester; flags when it has waited STARVE_LIMIT cycles.
module wbarb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CTR_W        = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat_c
);

  logic [CTR_W-1:0] r_count;

  assign o_sat_c = (r_count == CTR_W'(STARVE_LIMIT));

  // Clear wins over increment so a grant in the saturating cycle resets the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat_c) begin
      r_count <= r_count + CTR_W'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: writeback > round-robin(multdiv, special-reg), registered write.
// Define WBARB_STARVE_EN to add per-requester starvation counters that override writeback.
module wb_port_arbiter
  import wbarb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CTR_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  if ((1 << CTR_W) <= STARVE_LIMIT) begin : g_bad_cfg
    $error("wb_port_arbiter: CTR_W too narrow for STARVE_LIMIT");
  end

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_stall;
  logic               w_sat_md;
  logic               w_sat_spr;
  logic               w_star_md;
  logic               w_star_spr;
  logic [SEL_W-1:0]   w_sel;
  wr_req_t            w_in [NUM_REQ];
  wr_req_t            w_win;

  logic               r_rr;
  logic [SEL_W-1:0]   r_sel;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  assign w_req           = bus.req;
  assign w_in[REQ_WB]    = '{addr: bus.addr0, data: bus.data0};
  assign w_in[REQ_MD]    = '{addr: bus.addr1, data: bus.data1};
  assign w_in[REQ_SPR]   = '{addr: bus.addr2, data: bus.data2};

`ifdef WBARB_STARVE_EN
  wbarb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CTR_W        (CTR_W)
  ) u_ctr_md (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_req[REQ_MD] & ~w_gnt[REQ_MD]),
    .i_clr   (~w_req[REQ_MD] | w_gnt[REQ_MD]),
    .o_sat_c (w_sat_md)
  );

  wbarb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CTR_W        (CTR_W)
  ) u_ctr_spr (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_req[REQ_SPR] & ~w_gnt[REQ_SPR]),
    .i_clr   (~w_req[REQ_SPR] | w_gnt[REQ_SPR]),
    .o_sat_c (w_sat_spr)
  );
`else
  assign w_sat_md  = 1'b0;
  assign w_sat_spr = 1'b0;
`endif

  assign w_star_md  = w_sat_md  & w_req[REQ_MD];
  assign w_star_spr = w_sat_spr & w_req[REQ_SPR];

  // Starved > writeback > round-robin; r_rr=0 prefers multdiv.
  always_comb begin : arb
    w_gnt = '0;
    if (reset) begin
      w_gnt = '0;
    end else if (w_star_md && w_star_spr) begin
      if (r_rr) w_gnt[REQ_SPR] = 1'b1;
      else      w_gnt[REQ_MD]  = 1'b1;
    end else if (w_star_md) begin
      w_gnt[REQ_MD] = 1'b1;
    end else if (w_star_spr) begin
      w_gnt[REQ_SPR] = 1'b1;
    end else if (w_req[REQ_WB]) begin
      w_gnt[REQ_WB] = 1'b1;
    end else if (w_req[REQ_MD] && w_req[REQ_SPR]) begin
      if (r_rr) w_gnt[REQ_SPR] = 1'b1;
      else      w_gnt[REQ_MD]  = 1'b1;
    end else if (w_req[REQ_MD]) begin
      w_gnt[REQ_MD] = 1'b1;
    end else if (w_req[REQ_SPR]) begin
      w_gnt[REQ_SPR] = 1'b1;
    end
  end

  assign w_stall = reset ? '0 : (w_req & ~w_gnt);

  always_comb begin : wr_mux
    w_sel = gnt_to_sel(w_gnt);
    case (w_sel)
      SEL_1:   w_win = w_in[REQ_MD];
      SEL_2:   w_win = w_in[REQ_SPR];
      default: w_win = w_in[REQ_WB];
    endcase
  end

  // Writes to $r0 are granted but leave wr_en low and wr_data untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr      <= 1'b0;
      r_sel     <= SEL_0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (|w_gnt) begin
        r_sel <= w_sel;
        if (w_win.addr == R0_ADDR) begin
          r_wr_addr <= R0_ADDR;
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_win.addr;
          r_wr_data <= w_win.data;
        end
      end
      if (w_gnt[REQ_MD]) begin
        r_rr <= 1'b1;
      end else if (w_gnt[REQ_SPR]) begin
        r_rr <= 1'b0;
      end
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.stall   = w_stall;
  assign bus.sel     = r_sel;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, hand-written corner sequences, random run vs a reference model.
// Follows WBARB_STARVE_EN the same way the design does.
module tb_wb_port_arbiter;
  import wbarb_pkg::*;

  localparam int unsigned LIMIT = 4;
`ifdef WBARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CTR_W        (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] req;
    logic [4:0] a0, a1, a2;
    logic [2:0] gnt;
    logic       en;
    logic [1:0] sel;
    logic [4:0] waddr;
  } vec_t;
  vec_t tbl [15];

  // reference model state: consecutive wait cycles, preferred of {1,2}, registered write
  int          wt [3];
  int          pref;
  logic        m_en;
  logic [1:0]  m_sel;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  logic [2:0]  rq;
  logic [4:0]  ra [3];
  logic [31:0] rd [3];
  int          prob [3] = '{85, 45, 45};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkd(input int i, input logic [4:0] a);
    return 32'hC0DE_0000 + 32'(i << 8) + 32'(a);
  endfunction

  task automatic apply(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2);
    @(negedge clock);
    bus.req   = r;
    bus.addr0 = a0;  bus.data0 = mkd(0, a0);
    bus.addr1 = a1;  bus.data1 = mkd(1, a1);
    bus.addr2 = a2;  bus.data2 = mkd(2, a2);
    #1;
  endtask

  task automatic step(input string nm, input logic [2:0] r, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] eg,
                      input logic ee, input logic [1:0] es, input logic [4:0] ea);
    apply(r, a0, a1, a2);
    chk({nm, ".gnt"},   32'(bus.gnt),   32'(eg));
    chk({nm, ".stall"}, 32'(bus.stall), 32'(r & ~eg));
    @(posedge clock); #1;
    chk({nm, ".wr_en"},   32'(bus.wr_en),   32'(ee));
    chk({nm, ".sel"},     32'(bus.sel),     32'(es));
    chk({nm, ".wr_addr"}, 32'(bus.wr_addr), 32'(ea));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    bus.req = 3'b111;
    #1;
    chk("rst.gnt",   32'(bus.gnt),   32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    bus.req = 3'b000;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst.wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst.sel",     32'(bus.sel),     32'd0);
    chk("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst.wr_data", bus.wr_data,      32'd0);
  endtask

  // Winner from the rules: starved (tie -> pref) > req0 > req1/req2 alternated by pref.
  function automatic int pick(input logic [2:0] r);
    bit s1, s2;
    s1 = STARVE_ON && r[1] && (wt[1] >= int'(LIMIT));
    s2 = STARVE_ON && r[2] && (wt[2] >= int'(LIMIT));
    if (s1 && s2)         return pref;
    if (s1)               return 1;
    if (s2)               return 2;
    if (r[0])             return 0;
    if (r[1] && r[2])     return pref;
    if (r[1])             return 1;
    if (r[2])             return 2;
    return -1;
  endfunction

  initial begin
    int          g;
    logic [2:0]  eg;

    bus.req = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;

    //                 req     a0     a1      a2      gnt     en    sel    waddr
    tbl[0]  = '{3'b000, 5'd0, 5'd0,  5'd0,  3'b000, 1'b0, 2'b00, 5'd0};
    tbl[1]  = '{3'b001, 5'd3, 5'd0,  5'd0,  3'b001, 1'b1, 2'b00, 5'd3};
    tbl[2]  = '{3'b010, 5'd0, 5'd9,  5'd0,  3'b010, 1'b1, 2'b01, 5'd9};
    tbl[3]  = '{3'b110, 5'd0, 5'd10, 5'd11, 3'b100, 1'b1, 2'b10, 5'd11};
    tbl[4]  = '{3'b010, 5'd0, 5'd10, 5'd0,  3'b010, 1'b1, 2'b01, 5'd10};
    tbl[5]  = '{3'b110, 5'd0, 5'd12, 5'd13, 3'b100, 1'b1, 2'b10, 5'd13};
    tbl[6]  = '{3'b011, 5'd4, 5'd12, 5'd0,  3'b001, 1'b1, 2'b00, 5'd4};
    tbl[7]  = '{3'b010, 5'd0, 5'd12, 5'd0,  3'b010, 1'b1, 2'b01, 5'd12};
    tbl[8]  = '{3'b100, 5'd0, 5'd0,  5'd0,  3'b100, 1'b0, 2'b10, 5'd0};
    tbl[9]  = '{3'b000, 5'd0, 5'd0,  5'd0,  3'b000, 1'b0, 2'b10, 5'd0};
    tbl[10] = '{3'b111, 5'd5, 5'd6,  5'd7,  3'b001, 1'b1, 2'b00, 5'd5};
    tbl[11] = '{3'b111, 5'd5, 5'd6,  5'd7,  3'b001, 1'b1, 2'b00, 5'd5};
    tbl[12] = '{3'b110, 5'd0, 5'd6,  5'd7,  3'b010, 1'b1, 2'b01, 5'd6};
    tbl[13] = '{3'b100, 5'd0, 5'd0,  5'd7,  3'b100, 1'b1, 2'b10, 5'd7};
    tbl[14] = '{3'b001, 5'd0, 5'd0,  5'd0,  3'b001, 1'b0, 2'b00, 5'd0};

    // idle after reset
    do_reset();
    for (int k = 0; k < 5; k++) step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, SEL_0, 5'd0);

    for (int k = 0; k < 15; k++)
      step($sformatf("vec%0d", k), tbl[k].req, tbl[k].a0, tbl[k].a1, tbl[k].a2,
           tbl[k].gnt, tbl[k].en, tbl[k].sel, tbl[k].waddr);

    // continuous req0 with req1 waiting
    do_reset();
`ifdef WBARB_STARVE_EN
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        step("starve", 3'b011, 5'd3, 5'(21 + k / 5), 5'd0, 3'b010, 1'b1, SEL_1, 5'(21 + k / 5));
      else
        step("starve", 3'b011, 5'd3, 5'(21 + k / 5), 5'd0, 3'b001, 1'b1, SEL_0, 5'd3);
    end
`else
    for (int k = 0; k < 20; k++)
      step("no_starve", 3'b011, 5'd3, 5'd21, 5'd0, 3'b001, 1'b1, SEL_0, 5'd3);
`endif

    // reset in the cycle after a grant to req1
    do_reset();
    step("rst_a", 3'b111, 5'd5, 5'd6, 5'd7, 3'b001, 1'b1, SEL_0, 5'd5);
    step("rst_b", 3'b110, 5'd5, 5'd6, 5'd7, 3'b010, 1'b1, SEL_1, 5'd6);
    bus.req = 3'b100;
    reset   = 1'b1;
    #1;
    chk("midrst.wr_en", 32'(bus.wr_en), 32'd0);
    chk("midrst.gnt",   32'(bus.gnt),   32'd0);
    chk("midrst.stall", 32'(bus.stall), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    step("midrst_rr", 3'b110, 5'd5, 5'd8, 5'd7, 3'b010, 1'b1, SEL_1, 5'd8);
    for (int k = 0; k < 3; k++)
      step("midrst_ctr", 3'b101, 5'd5, 5'd8, 5'd7, 3'b001, 1'b1, SEL_0, 5'd5);
`ifdef WBARB_STARVE_EN
    step("midrst_last", 3'b101, 5'd5, 5'd8, 5'd7, 3'b100, 1'b1, SEL_2, 5'd7);
`else
    step("midrst_last", 3'b101, 5'd5, 5'd8, 5'd7, 3'b001, 1'b1, SEL_0, 5'd5);
`endif

    // $r0 write is granted but suppressed, wr_data keeps the previous write
    do_reset();
    step("r0_pre", 3'b100, 5'd0, 5'd0, 5'd9, 3'b100, 1'b1, SEL_2, 5'd9);
    apply(3'b100, 5'd0, 5'd0, 5'd0);
    bus.data2 = 32'hDEAD_BEEF;
    #1;
    chk("r0.gnt", 32'(bus.gnt), 32'(3'b100));
    @(posedge clock); #1;
    chk("r0.wr_en",   32'(bus.wr_en),   32'd0);
    chk("r0.wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("r0.sel",     32'(bus.sel),     32'(SEL_2));
    chk("r0.wr_data", bus.wr_data,      mkd(2, 5'd9));

    // random requesters holding until granted, against the model
    do_reset();
    for (int i = 0; i < 3; i++) wt[i] = 0;
    pref = 1; m_en = 1'b0; m_sel = 2'b00; m_addr = '0; m_data = '0;
    rq = '0;
    g  = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rq[i] || g == i) begin
          rq[i] = ($urandom_range(99) < 32'(prob[i]));
          ra[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
          rd[i] = $urandom;
        end
      end
      @(negedge clock);
      bus.req   = rq;
      bus.addr0 = ra[0]; bus.data0 = rd[0];
      bus.addr1 = ra[1]; bus.data1 = rd[1];
      bus.addr2 = ra[2]; bus.data2 = rd[2];
      #1;
      g  = pick(rq);
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      chk("rnd.gnt",   32'(bus.gnt),   32'(eg));
      chk("rnd.stall", 32'(bus.stall), 32'(rq & ~eg));
      for (int i = 1; i < 3; i++)
        wt[i] = (rq[i] && g != i) ? ((wt[i] + 1 > int'(LIMIT)) ? int'(LIMIT) : wt[i] + 1) : 0;
      if (g == 1) pref = 2;
      else if (g == 2) pref = 1;
      m_en = 1'b0;
      if (g >= 0) begin
        m_sel = 2'(g);
        if (ra[g] == 5'd0) begin
          m_addr = 5'd0;
        end else begin
          m_en   = 1'b1;
          m_addr = ra[g];
          m_data = rd[g];
        end
      end
      @(posedge clock); #1;
      chk("rnd.wr_en",   32'(bus.wr_en),   32'(m_en));
      chk("rnd.sel",     32'(bus.sel),     32'(m_sel));
      chk("rnd.wr_addr", 32'(bus.wr_addr), 32'(m_addr));
      chk("rnd.wr_data", bus.wr_data,      m_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
